vga_timing_gen: RTL

- Parametrised VGA raster engine for the clock/calendar display path.
- Generates hsync/vsync, pixel coordinates and blanking from the system clock via an integer pixel-clock divider.
- Delays sync and blank by a configurable pipeline depth so they align with the latency of an external character/font renderer.
- Blanks COLOUR_OUT outside the active area; resolution, polarity and colour width are all set by parameters.

---
 rtl/vga_timing_gen.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster engine.
// Divides CLK down to a pixel tick, walks pix_x/pix_y over the full raster,
// and delays sync/blank by PIPE ticks to line up with an external renderer.
module vga_timing_gen #(
    parameter  int H_ACTIVE = 640,
    parameter  int H_FP     = 16,
    parameter  int H_SYNC   = 96,
    parameter  int H_BP     = 48,
    parameter  int V_ACTIVE = 480,
    parameter  int V_FP     = 10,
    parameter  int V_SYNC   = 2,
    parameter  int V_BP     = 33,
    parameter  int CLK_DIV  = 4,
    parameter  int HS_POL   = 0,
    parameter  int VS_POL   = 0,
    parameter  int COLOR_W  = 12,
    parameter  int PIPE     = 2,
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic               en,
    input  logic [COLOR_W-1:0] pixel_in,
    output logic [HW-1:0]      pix_x,
    output logic [VW-1:0]      pix_y,
    output logic               pix_tick,
    output logic               line_start,
    output logic               frame_start,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] COLOUR_OUT
);

    localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    // IDLE: no coordinate issued yet; the first tick loads (0,0) instead of counting.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DW-1:0]      r_div;
    logic               w_adv;
    logic [HW-1:0]      r_x;
    logic [HW-1:0]      w_x_nxt;
    logic [VW-1:0]      r_y;
    logic [VW-1:0]      w_y_nxt;
    logic               r_tick;
    logic               r_line;
    logic               r_frame;
    logic [PIPE-1:0]    r_act_d;
    logic [PIPE-1:0]    r_hs_d;
    logic [PIPE-1:0]    r_vs_d;
    logic [COLOR_W-1:0] r_col;
    logic               w_act;
    logic               w_hs;
    logic               w_vs;
    logic               w_act_next;

    if (CLK_DIV < 1 || PIPE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_param_check
        $error("vga_timing_gen: illegal parameter set");
    end

    assign w_adv = en && (r_div == DW'(CLK_DIV - 1));

    // Pixel-clock divider: counts 0..CLK_DIV-1, held at 0 while disabled
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (!en || w_adv) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Run-state register
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Run-state next: enter RUN on the first tick, fall back to IDLE when disabled
    always_comb begin
        w_state_nxt = r_state;
        if (!en) begin
            w_state_nxt = ST_IDLE;
        end else if (w_adv) begin
            w_state_nxt = ST_RUN;
        end
    end

    // Next coordinate: (0,0) on the first tick, then raster order with wrap
    always_comb begin
        w_x_nxt = r_x + 1'b1;
        w_y_nxt = r_y;
        if (r_state == ST_IDLE) begin
            w_x_nxt = '0;
            w_y_nxt = '0;
        end else if (r_x == HW'(H_TOTAL - 1)) begin
            w_x_nxt = '0;
            w_y_nxt = (r_y == VW'(V_TOTAL - 1)) ? '0 : r_y + 1'b1;
        end
    end

    // Raw timing flags for the issued coordinate; inactive before the first tick
    always_comb begin
        w_act = 1'b0;
        w_hs  = 1'b0;
        w_vs  = 1'b0;
        if (r_state == ST_RUN) begin
            w_act = (r_x < HW'(H_ACTIVE)) && (r_y < VW'(V_ACTIVE));
            w_hs  = (r_x >= HW'(HS_START)) && (r_x < HW'(HS_END));
            w_vs  = (r_y >= VW'(VS_START)) && (r_y < VW'(VS_END));
        end
    end

    // Active flag about to enter the last pipeline stage gates the colour register
    if (PIPE == 1) begin : g_next_direct
        assign w_act_next = w_act;
    end else begin : g_next_stage
        assign w_act_next = r_act_d[PIPE-2];
    end

    // Coordinate counters and unaligned strobes
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_tick  <= 1'b0;
            r_line  <= 1'b0;
            r_frame <= 1'b0;
        end else if (!en) begin
            r_x     <= '0;
            r_y     <= '0;
            r_tick  <= 1'b0;
            r_line  <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_tick  <= w_adv;
            r_line  <= w_adv && (w_x_nxt == '0);
            r_frame <= w_adv && (w_x_nxt == '0) && (w_y_nxt == '0);
            if (w_adv) begin
                r_x <= w_x_nxt;
                r_y <= w_y_nxt;
            end
        end
    end

    // Alignment pipeline for blank/sync plus blanked colour register
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_act_d <= '0;
            r_hs_d  <= '0;
            r_vs_d  <= '0;
            r_col   <= '0;
        end else if (!en) begin
            r_act_d <= '0;
            r_hs_d  <= '0;
            r_vs_d  <= '0;
            r_col   <= '0;
        end else if (w_adv) begin
            r_act_d <= PIPE'({r_act_d, w_act});
            r_hs_d  <= PIPE'({r_hs_d, w_hs});
            r_vs_d  <= PIPE'({r_vs_d, w_vs});
            r_col   <= w_act_next ? pixel_in : '0;
        end
    end

    assign pix_x       = r_x;
    assign pix_y       = r_y;
    assign pix_tick    = r_tick;
    assign line_start  = r_line;
    assign frame_start = r_frame;
    assign video_on    = r_act_d[PIPE-1];
    assign hsync       = (HS_POL != 0) ? r_hs_d[PIPE-1] : ~r_hs_d[PIPE-1];
    assign vsync       = (VS_POL != 0) ? r_vs_d[PIPE-1] : ~r_vs_d[PIPE-1];
    assign COLOUR_OUT  = r_col;

endmodule
